// File: rtl/qrd_feeder.sv
// qrd_feeder: ping-pong matrix buffer feeding a QRD array with skewed rows of [H | I]
module qrd_feeder #(
  parameter int N = 4,
  parameter int W = 14,
  parameter int FRAC = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [W-1:0]   in_r,
  input  logic [W-1:0]   in_i,
  output logic           in_ready,
  input  logic           core_ready,
  output logic [N*W-1:0] row_out_r,
  output logic [N*W-1:0] row_out_i,
  output logic [N-2:0]   row_out_f,
  output logic           busy,
  output logic           mat_done
);
  localparam int NN = N * N;
  localparam int AW = $clog2(NN);
  localparam int TW = $clog2(3 * N - 1);
  localparam logic [W-1:0] ONE = W'(1) << FRAC;
  typedef enum logic {IDLE, FEED} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [AW-1:0] ld_q, ld_d;
  logic [1:0] full_q, full_d;
  logic wr_q, wr_d, rd_q, rd_d, done_q, done_d;
  logic [N*W-1:0] r_q, r_d, i_q, i_d, sr, si;
  logic [N-2:0] f_q, f_d, sf;
  logic [W-1:0] mem_r [2][NN];
  logic [W-1:0] mem_i [2][NN];
  logic acc, fill, step, last;
  logic [AW-1:0] a;
  int c;

  assign in_ready = !rst && !full_q[wr_q];
  assign acc = in_valid && in_ready;
  assign fill = acc && ld_q == AW'(NN - 1);
  assign step = core_ready && full_q[rd_q];
  assign last = step && t_q == TW'(3 * N - 2);

  // Row k lags row k-1 by one step; columns past N carry the identity block.
  always_comb begin
    sr = '0;
    si = '0;
    sf = '0;
    c = 0;
    a = '0;
    for (int k = 0; k < N; k++) begin
      c = int'(t_q) - k;
      a = AW'(k * N + c);
      sr[k*W +: W] = (c >= 0 && c < N) ? mem_r[rd_q][a] : (c - N == k) ? ONE : '0;
      si[k*W +: W] = (c >= 0 && c < N) ? mem_i[rd_q][a] : '0;
    end
    for (int k = 0; k < N - 1; k++) sf[k] = int'(t_q) == 2 * k;
  end

  always_comb begin
    full_d = full_q;
    if (fill) full_d[wr_q] = 1'b1;
    if (last) full_d[rd_q] = 1'b0;
    ld_d = fill ? '0 : ld_q + AW'(acc);
    wr_d = wr_q ^ fill;
    rd_d = rd_q ^ last;
    done_d = last;
    state_d = state_q;
    t_d = t_q;
    r_d = r_q;
    i_d = i_q;
    f_d = f_q;
    if (step) begin
      r_d = sr;
      i_d = si;
      f_d = sf;
      t_d = last ? '0 : t_q + 1'b1;
      state_d = (last && !full_d[!rd_q]) ? IDLE : FEED;
    end else if (t_q == '0) begin
      state_d = IDLE;
      r_d = '0;
      i_d = '0;
      f_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q <= '0;
      ld_q <= '0;
      full_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      r_q <= '0;
      i_q <= '0;
      f_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      ld_q <= ld_d;
      full_q <= full_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      r_q <= r_d;
      i_q <= i_d;
      f_q <= f_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      mem_r[wr_q][ld_q] <= in_r;
      mem_i[wr_q][ld_q] <= in_i;
    end
  end

  assign row_out_r = r_q;
  assign row_out_i = i_q;
  assign row_out_f = f_q;
  assign busy = state_q == FEED;
  assign mat_done = done_q;
endmodule

// File: tb/tb_qrd_feeder.sv
// tb_qrd_feeder: directed tables plus randomized traffic checked against a queue-based model
module tb_qrd_feeder;
  localparam int N = 4, W = 14, NN = 16, LAST = 3 * N - 2, NV = 16;
  typedef logic [NN*W-1:0] mat_t;
  typedef struct { int t; int k; int er; int ei; logic [N-2:0] ef; } vec_t;

  logic clk = 0, rst = 1, in_valid = 0, core_ready = 0;
  logic [W-1:0] in_r = '0, in_i = '0;
  logic in_ready, busy, mat_done;
  logic [N*W-1:0] row_out_r, row_out_i;
  logic [N-2:0] row_out_f;
  logic v2 = 0, cr2 = 0;
  logic [W-1:0] r2 = '0, i2 = '0;
  logic rdy2, busy2, done2;
  logic [2*W-1:0] or2, oi2;
  logic [0:0] of2;
  int checks = 0, errors = 0, n_dones = 0;

  mat_t bk_r[$], bk_i[$];
  mat_t ld_r, ld_i, dr, di;
  int ld_n = 0, mt = 0, st = 0;
  bit stepped = 0, last_acc = 0;
  logic [N*W-1:0] e_r = '0, e_i = '0;
  logic [N-2:0] e_f = '0;
  logic e_busy = 0, e_done = 0;
  logic [W-1:0] cap_r [11][N];
  logic [W-1:0] cap_i [11][N];
  logic [N-2:0] cap_f [11];
  vec_t tv [NV];

  always #5 clk = ~clk;

  qrd_feeder #(.N(N), .W(W), .FRAC(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i), .in_ready(in_ready),
    .core_ready(core_ready), .row_out_r(row_out_r), .row_out_i(row_out_i), .row_out_f(row_out_f),
    .busy(busy), .mat_done(mat_done));

  qrd_feeder #(.N(2), .W(W), .FRAC(10)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_r(r2), .in_i(i2), .in_ready(rdy2),
    .core_ready(cr2), .row_out_r(or2), .row_out_i(oi2), .row_out_f(of2),
    .busy(busy2), .mat_done(done2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void ref_step(input mat_t mr, input mat_t mi, input int t,
                                   output logic [N*W-1:0] er, output logic [N*W-1:0] ei,
                                   output logic [N-2:0] ef);
    er = '0;
    ei = '0;
    ef = '0;
    for (int k = 0; k < N; k++) begin
      int cc;
      cc = t - k;
      if (cc >= 0 && cc < N) begin
        er[k*W +: W] = mr[(k*N+cc)*W +: W];
        ei[k*W +: W] = mi[(k*N+cc)*W +: W];
      end else if (cc - N == k) er[k*W +: W] = W'(1 << 10);
    end
    for (int k = 0; k < N - 1; k++) ef[k] = (t == 2 * k);
  endfunction

  initial forever begin
    @(posedge clk);
    stepped = 0;
    last_acc = 0;
    if (rst) begin
      bk_r.delete();
      bk_i.delete();
      ld_n = 0;
      mt = 0;
      e_r = '0; e_i = '0; e_f = '0; e_busy = 0; e_done = 0;
    end else begin
      last_acc = in_valid && bk_r.size() < 2;
      e_done = 0;
      if (core_ready && bk_r.size() > 0) begin
        ref_step(bk_r[0], bk_i[0], mt, e_r, e_i, e_f);
        stepped = 1;
        st = mt;
        if (mt == LAST) begin
          void'(bk_r.pop_front());
          void'(bk_i.pop_front());
          e_done = 1;
          mt = 0;
        end else mt++;
      end else if (mt == 0) begin
        e_r = '0; e_i = '0; e_f = '0; e_busy = 0;
      end
      if (last_acc) begin
        ld_r[ld_n*W +: W] = in_r;
        ld_i[ld_n*W +: W] = in_i;
        ld_n++;
        if (ld_n == NN) begin
          bk_r.push_back(ld_r);
          bk_i.push_back(ld_i);
          ld_n = 0;
        end
      end
      if (stepped) e_busy = !e_done || bk_r.size() > 0;
    end
    @(negedge clk);
    chk("model_row_r", 64'(row_out_r), 64'(e_r));
    chk("model_row_i", 64'(row_out_i), 64'(e_i));
    chk("model_row_f", 64'(row_out_f), 64'(e_f));
    chk("model_busy", 64'(busy), 64'(e_busy));
    chk("model_mat_done", 64'(mat_done), 64'(e_done));
    chk("model_in_ready", 64'(in_ready), 64'(!rst && bk_r.size() < 2));
    if (stepped && st < 11) begin
      for (int k = 0; k < N; k++) begin
        cap_r[st][k] = row_out_r[k*W +: W];
        cap_i[st][k] = row_out_i[k*W +: W];
      end
      cap_f[st] = row_out_f;
    end
    if (mat_done) n_dones++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    n_dones = 0;
    for (int t = 0; t < 11; t++) begin
      for (int k = 0; k < N; k++) begin
        cap_r[t][k] = 14'h1555;
        cap_i[t][k] = 14'h1555;
      end
      cap_f[t] = '1;
    end
  endtask

  task automatic load(input mat_t mr, input mat_t mi, input int bub);
    for (int e = 0; e < NN; e++) begin
      int tries;
      tries = 0;
      in_r = mr[e*W +: W];
      in_i = mi[e*W +: W];
      do begin
        in_valid = ($urandom_range(99) >= bub);
        tick;
        tries++;
      end while (!last_acc && tries < 200);
      if (!last_acc) begin
        checks++;
        errors++;
        $display("FAIL load_timeout: element %0d not accepted, required within 200 cycles", e);
      end
    end
    in_valid = 0;
  endtask

  task automatic run_table(input string tag);
    for (int j = 0; j < NV; j++) begin
      logic [W-1:0] xr, xi;
      xr = W'(tv[j].er);
      xi = W'(tv[j].ei);
      chk($sformatf("%s_t%0d_row%0d_r", tag, tv[j].t, tv[j].k), 64'(cap_r[tv[j].t][tv[j].k]), 64'(xr));
      chk($sformatf("%s_t%0d_row%0d_i", tag, tv[j].t, tv[j].k), 64'(cap_i[tv[j].t][tv[j].k]), 64'(xi));
      chk($sformatf("%s_t%0d_f", tag, tv[j].t), 64'(cap_f[tv[j].t]), 64'(tv[j].ef));
    end
    chk({tag, "_done_count"}, 64'(n_dones), 64'd1);
  endtask

  initial begin
    int n2r [5][2];
    int n2i [5][2];
    bit ok;
    tv = '{'{0, 0, 1, -1, 3'b001}, '{0, 1, 0, 0, 3'b001}, '{1, 0, 2, -2, 3'b000},
           '{1, 1, 5, -5, 3'b000}, '{2, 0, 3, -3, 3'b010}, '{3, 3, 13, -13, 3'b000},
           '{4, 0, 1024, 0, 3'b100}, '{4, 2, 11, -11, 3'b100}, '{5, 2, 12, -12, 3'b000},
           '{6, 2, 0, 0, 3'b000}, '{6, 3, 16, -16, 3'b000}, '{7, 3, 0, 0, 3'b000},
           '{8, 2, 1024, 0, 3'b000}, '{9, 1, 0, 0, 3'b000}, '{10, 0, 0, 0, 3'b000},
           '{10, 3, 1024, 0, 3'b000}};
    n2r = '{'{1, 0}, '{2, 3}, '{1024, 4}, '{0, 0}, '{0, 1024}};
    n2i = '{'{-1, 0}, '{-2, -3}, '{0, -4}, '{0, 0}, '{0, 0}};
    for (int e = 0; e < NN; e++) begin
      dr[e*W +: W] = W'(e + 1);
      di[e*W +: W] = W'(-(e + 1));
    end
    repeat (3) tick;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rows", 64'(row_out_r | row_out_i), 64'd0);
    chk("rst_done", 64'(mat_done), 64'd0);
    tick;
    rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    clr;
    core_ready = 1;
    load(dr, di, 0);
    repeat (15) tick;
    run_table("base");

    clr;
    core_ready = 0;
    load(dr, di, 0);
    core_ready = 1;
    repeat (6) tick;
    core_ready = 0;
    repeat (3) tick;
    @(negedge clk);
    chk("stall_row2_r", 64'(row_out_r[2*W +: W]), 64'(W'(12)));
    chk("stall_busy", 64'(busy), 64'd1);
    core_ready = 1;
    repeat (8) tick;
    run_table("stall");

    clr;
    core_ready = 1;
    load(dr, di, 50);
    repeat (15) tick;
    run_table("bubble");

    core_ready = 0;
    load(dr, di, 0);
    in_valid = 1;
    for (int j = 0; j < 8; j++) begin
      in_r = dr[j*W +: W];
      in_i = di[j*W +: W];
      core_ready = (j >= 3);
      tick;
    end
    in_valid = 0;
    rst = 1;
    tick;
    rst = 0;
    @(negedge clk);
    chk("midrst_rows", 64'(row_out_r | row_out_i), 64'd0);
    chk("midrst_f", 64'(row_out_f), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    clr;
    load(dr, di, 0);
    repeat (15) tick;
    run_table("reload");

    clr;
    core_ready = 0;
    in_valid = 1;
    for (int e = 0; e < 32; e++) begin
      in_r = W'($urandom);
      in_i = W'($urandom);
      tick;
    end
    in_valid = 0;
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    core_ready = 1;
    ok = 0;
    for (int w = 0; w < 30; w++) begin
      @(negedge clk);
      if (mat_done) begin
        chk("ready_at_done", 64'(in_ready), 64'd1);
        chk("b2b_busy", 64'(busy), 64'd1);
        ok = 1;
        break;
      end
      chk("ready_low_until_done", 64'(in_ready), 64'd0);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL first_done_timeout: mat_done not seen, required within 30 cycles");
    end
    load(dr, di, 0);
    repeat (40) tick;
    chk("stream_done_count", 64'(n_dones), 64'd3);

    for (int cyc = 0; cyc < 800; cyc++) begin
      in_valid = $urandom_range(1);
      in_r = W'($urandom);
      in_i = W'($urandom);
      core_ready = ($urandom_range(99) < 70);
      rst = ($urandom_range(199) == 0);
      tick;
    end
    rst = 0;
    in_valid = 0;
    core_ready = 1;
    repeat (40) tick;

    cr2 = 1;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      chk("n2_in_ready", 64'(rdy2), 64'd1);
      v2 = 1;
      r2 = W'(e + 1);
      i2 = W'(-(e + 1));
      tick;
    end
    v2 = 0;
    for (int t = 0; t < 5; t++) begin
      tick;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        logic [W-1:0] xr, xi;
        xr = W'(n2r[t][k]);
        xi = W'(n2i[t][k]);
        chk($sformatf("n2_t%0d_row%0d_r", t, k), 64'(or2[k*W +: W]), 64'(xr));
        chk($sformatf("n2_t%0d_row%0d_i", t, k), 64'(oi2[k*W +: W]), 64'(xi));
      end
      chk($sformatf("n2_t%0d_f", t), 64'(of2), 64'(t == 0));
      chk($sformatf("n2_t%0d_done", t), 64'(done2), 64'(t == 4));
    end
    tick;
    @(negedge clk);
    chk("n2_idle_busy", 64'(busy2), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
